// File: rtl/block_stream_emitter_if.sv
// Command and character-stream bundle for block_stream_emitter.
// The emitter takes the slave side; the command source or bench takes master.
interface block_stream_emitter_if #(
  parameter int DEPTH_W = 16
);
  logic               cmd_valid;
  logic               cmd_op;
  logic               cmd_ready;
  logic [7:0]         out;
  logic               out_valid;
  logic [DEPTH_W-1:0] depth;
  logic               balanced;
  logic               err;

  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, out, out_valid, depth, balanced, err
  );

  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, out, out_valid, depth, balanced, err
  );
endinterface

// File: rtl/block_stream_emitter.sv
// Turns open/close commands into "begin "/"end " chars, one per clk, first char the cycle after accept;
// a new command is taken only in IDLE or on a token's last char, otherwise ignored. BLOCK_EMIT_UPPER_EN selects uppercase letters.
module block_stream_emitter #(
  parameter int DEPTH_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  block_stream_emitter_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [7:0] CH_SP = 8'h20;
`ifdef BLOCK_EMIT_UPPER_EN
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_G = 8'h47;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_D = 8'h44;
`else
  localparam logic [7:0] CH_B = 8'h62;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_G = 8'h67;
  localparam logic [7:0] CH_I = 8'h69;
  localparam logic [7:0] CH_N = 8'h6E;
  localparam logic [7:0] CH_D = 8'h64;
`endif

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t             state, state_nxt;
  logic [2:0]         idx, idx_nxt;
  logic               op, op_nxt;
  logic [7:0]         out_q, out_nxt;
  logic               out_vld_q, out_vld_nxt;
  logic [DEPTH_W-1:0] depth_q, depth_nxt;
  logic               err_q, err_nxt;
  logic [2:0]         last;
  logic               accept;

  function automatic logic [7:0] tok_char(input logic close, input logic [2:0] i);
    logic [7:0] c;
    c = CH_SP;
    if (close) begin
      case (i)
        3'd0:    c = CH_E;
        3'd1:    c = CH_N;
        3'd2:    c = CH_D;
        default: c = CH_SP;
      endcase
    end else begin
      case (i)
        3'd0:    c = CH_B;
        3'd1:    c = CH_E;
        3'd2:    c = CH_G;
        3'd3:    c = CH_I;
        3'd4:    c = CH_N;
        default: c = CH_SP;
      endcase
    end
    return c;
  endfunction

  assign last          = op ? 3'd3 : 3'd5;
  assign bus.cmd_ready = (state == IDLE) || ((state == EMIT) && (idx == last));
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    op_nxt      = op;
    out_nxt     = out_q;
    out_vld_nxt = out_vld_q;
    depth_nxt   = depth_q;
    err_nxt     = err_q;

    if (accept) begin
      state_nxt   = EMIT;
      idx_nxt     = 3'd0;
      op_nxt      = bus.cmd_op;
      out_nxt     = tok_char(bus.cmd_op, 3'd0);
      out_vld_nxt = 1'b1;
      // Error cases still emit the token; only the counter refuses to move.
      if (!bus.cmd_op) begin
        if (depth_q == DEPTH_MAX) err_nxt = 1'b1;
        else                      depth_nxt = depth_q + 1'b1;
      end else begin
        if (depth_q == '0) err_nxt = 1'b1;
        else               depth_nxt = depth_q - 1'b1;
      end
    end else if (state == EMIT) begin
      if (idx != last) begin
        idx_nxt = idx + 3'd1;
        out_nxt = tok_char(op, idx_nxt);
      end else begin
        state_nxt   = IDLE;
        idx_nxt     = 3'd0;
        out_nxt     = CH_SP;
        out_vld_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      op        <= 1'b0;
      out_q     <= CH_SP;
      out_vld_q <= 1'b0;
      depth_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      op        <= op_nxt;
      out_q     <= out_nxt;
      out_vld_q <= out_vld_nxt;
      depth_q   <= depth_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_vld_q;
  assign bus.depth     = depth_q;
  assign bus.err       = err_q;
  assign bus.balanced  = (depth_q == '0) && !err_q && (state == IDLE);

endmodule

// File: tb/tb_block_stream_emitter.sv
// Scoreboard bench for block_stream_emitter: token chars queued at accept, popped as the stream appears.
module tb_block_stream_emitter;
  localparam int DW = 2;
  localparam logic [DW-1:0] DMAX = '1;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   run_len = 0;
  int   last_run = 0;
  logic [7:0] exp_q[$];
  int   md;
  logic merr;

  block_stream_emitter_if #(.DEPTH_W(DW)) bus ();

  block_stream_emitter #(.DEPTH_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] exp_char(input logic op, input int i);
    string s;
    logic [7:0] c;
    s = op ? "end " : "begin ";
    c = s[i];
`ifdef BLOCK_EMIT_UPPER_EN
    if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
`endif
    return c;
  endfunction

  // Stream monitor: every valid char must match the scoreboard head; idle filler is a space.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        run_len++;
        if (exp_q.size() == 0) chk("unexpected_valid", bus.out_valid, 1'b0);
        else                   chk("char", bus.out, exp_q.pop_front());
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
        chk("idle_fill", bus.out, 8'h20);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 1'b0;
    @(negedge clk);
    exp_q.delete();
    md = 0;
    merr = 1'b0;
    run_len = 0;
    reset = 1'b0;
  endtask

  task automatic send(input logic op);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    while (!bus.cmd_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("ready_timeout", bus.cmd_ready, 1'b1);
      return;
    end
    for (int i = 0; i < (op ? 4 : 6); i++) exp_q.push_back(exp_char(op, i));
    if (!op) begin
      if (md == int'(DMAX)) merr = 1'b1;
      else                  md++;
    end else begin
      if (md == 0) merr = 1'b1;
      else         md--;
    end
    @(posedge clk);
    #1;
    chk("depth", bus.depth, md);
    chk("err", bus.err, merr);
  endtask

  task automatic stop_cmd();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid && n < 40);
    #1;
    chk("drain", bus.out_valid, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 1'b0;
    md = 0;
    merr = 1'b0;
    do_reset();

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_out", bus.out, 8'h20);
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_depth", bus.depth, 0);
      chk("rst_balanced", bus.balanced, 1'b1);
      chk("rst_ready", bus.cmd_ready, 1'b1);
    end

    // Single open: ready low for 5 cycles, high on the trailing space
    send(1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) bus.cmd_valid = 1'b0;
      chk("open_ready", bus.cmd_ready, (i == 6));
      chk("open_unbal", bus.balanced, 1'b0);
    end
    wait_idle();
    chk("open_still_unbal", bus.balanced, 1'b0);
    send(1'b1);
    stop_cmd();
    wait_idle();
    chk("close_balanced", bus.balanced, 1'b1);

    // Back-to-back nesting: 20 contiguous chars
    last_run = 0;
    send(1'b0);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    stop_cmd();
    wait_idle();
    chk("b2b_run_len", last_run, 20);
    chk("b2b_err", bus.err, 1'b0);
    chk("b2b_balanced", bus.balanced, 1'b1);

    // Close from depth 0 sets sticky err
    do_reset();
    send(1'b1);
    send(1'b0);
    send(1'b1);
    stop_cmd();
    wait_idle();
    chk("uf_err_sticky", bus.err, 1'b1);
    chk("uf_depth", bus.depth, 0);
    chk("uf_unbal", bus.balanced, 1'b0);
    do_reset();
    #1;
    chk("uf_err_cleared", bus.err, 1'b0);
    chk("uf_rebalanced", bus.balanced, 1'b1);

    // Async reset in the middle of "begin "
    send(1'b0);
    stop_cmd();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_char_g", bus.out, exp_char(1'b0, 2));
    reset = 1'b1;
    #1;
    chk("arst_out", bus.out, 8'h20);
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_depth", bus.depth, 0);
    chk("arst_ready", bus.cmd_ready, 1'b1);
    exp_q.delete();
    md = 0;
    merr = 1'b0;
    run_len = 0;
    @(negedge clk);
    reset = 1'b0;
    last_run = 0;
    send(1'b0);
    stop_cmd();
    wait_idle();
    chk("arst_full_token", last_run, 6);

    // Saturation at max depth
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b0);
    for (int i = 0; i < 3; i++) send(1'b1);
    stop_cmd();
    wait_idle();
    chk("sat_err", bus.err, 1'b1);
    chk("sat_depth_back", bus.depth, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
